// File: rtl/chess_turn_ctrl_if.sv
// Button, timer-flag and game-status signals of the chess turn controller.
// The master side is the controller; the slave side is the board/timers.
interface chess_turn_ctrl_if #(parameter int MOVE_W = 6);
    logic              btn_start;
    logic              btn_p1;
    logic              btn_p2;
    logic              zero1;
    logic              zero2;
    logic              start;
    logic              player;
    logic              paused;
    logic              game_over;
    logic              winner;
    logic [MOVE_W-1:0] moves;

    modport master (
        input  btn_start, btn_p1, btn_p2, zero1, zero2,
        output start, player, paused, game_over, winner, moves
    );

    modport slave (
        output btn_start, btn_p1, btn_p2, zero1, zero2,
        input  start, player, paused, game_over, winner, moves
    );
endinterface

// File: rtl/chess_turn_ctrl.sv
// Chess clock game-control FSM: button conditioning, turn hand-off, move count, winner latch.
// Optional per-button debounce is enabled with the CHESS_DEBOUNCE_EN macro.
module chess_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic rdy,
    input  logic btn,
    output logic ev
);
    logic s1, s2, lvl, lvl_q, armed;

`ifdef CHESS_DEBOUNCE_EN
    logic [3:0] cnt;
    logic       db;

    always_ff @(posedge clk) begin
        if (reset) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (s2 == db) begin
            cnt <= '0;
        end else if (cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
            db  <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    assign lvl = db;
`else
    logic unused_dbc;
    assign unused_dbc = ^32'(DEBOUNCE_CYCLES);
    assign lvl = s2;
`endif

    // armed only once the synchronizer has shown the button released, so a
    // button held through reset cannot fire until pressed again
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            lvl_q <= lvl;
            if (rdy && !s2) armed <= 1'b1;
        end
    end

    assign ev = lvl & ~lvl_q & armed;
endmodule

module chess_turn_ctrl #(
    parameter int MOVE_W          = 6,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic              clk_four,
    input  logic              reset,
    chess_turn_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;

    state_t            state;
    logic [1:0]        vld_pipe;
    logic [2:0]        btn, ev;
    logic              ev_turn;
    logic              start_q, player_q, paused_q, over_q, winner_q;
    logic [MOVE_W-1:0] moves_q;

    assign btn = {bus.btn_p2, bus.btn_p1, bus.btn_start};

    // synchronizer outputs are meaningful two edges after reset
    always_ff @(posedge clk_four) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[0], 1'b1};
    end

    chess_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [2:0] (
        .clk   (clk_four),
        .reset (reset),
        .rdy   (vld_pipe[1]),
        .btn   (btn),
        .ev    (ev)
    );

    assign ev_turn = player_q ? ev[2] : ev[1];

    always_ff @(posedge clk_four) begin
        if (reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            player_q <= 1'b0;
            paused_q <= 1'b0;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
            moves_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev[0]) begin
                        state    <= RUN;
                        start_q  <= 1'b1;
                        player_q <= 1'b0;
                    end
                end
                RUN, PAUSE: begin
                    if (bus.zero1 || bus.zero2) begin
                        state    <= OVER;
                        start_q  <= 1'b0;
                        paused_q <= 1'b0;
                        over_q   <= 1'b1;
                        winner_q <= bus.zero1;
                    end else if (ev[0]) begin
                        state    <= (state == RUN) ? PAUSE : RUN;
                        start_q  <= (state == PAUSE);
                        paused_q <= (state == RUN);
                    end else if (state == RUN && ev_turn) begin
                        player_q <= ~player_q;
                        if (moves_q != '1) moves_q <= moves_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.start     = start_q;
    assign bus.player    = player_q;
    assign bus.paused    = paused_q;
    assign bus.game_over = over_q;
    assign bus.winner    = winner_q;
    assign bus.moves     = moves_q;
endmodule
